// File: rtl/fifo_line_pkg.sv
// Shared types and constants for the pixel line-buffer controller.
package fifo_line_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_LINE = 2'd1,
      DRAIN   = 2'd2
   } rd_state_t;

   localparam int unsigned DROP_CNT_W = 16;

endpackage

// File: rtl/fifo_line_ctrl.sv
// Whole-line admission into the line FIFO and framed single-line readout.
module fifo_line_ctrl
   import fifo_line_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned DEPTH_WIDTH = 12,
   parameter int unsigned H_ACTIVE    = 1280,
   parameter int unsigned LINE_CNT_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  out_req,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_eol,
   output logic                  out_busy,
   output logic [LINE_CNT_W-1:0] lines_stored,
   output logic                  drop_pulse,
   output logic [DROP_CNT_W-1:0] drop_cnt,
   output logic                  fifo_wr_en,
   output logic [DATA_WIDTH-1:0] fifo_wr_data,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_wr_full,
   input  logic                  fifo_rd_empty
);

   localparam int unsigned OCC_W = DEPTH_WIDTH + 1;
   localparam logic [OCC_W-1:0] LAST_PIX  = OCC_W'(H_ACTIVE - 1);
   localparam logic [OCC_W:0]   LINE_LEN  = (OCC_W + 1)'(H_ACTIVE);
   localparam logic [OCC_W:0]   FIFO_SIZE = {2'b01, {DEPTH_WIDTH{1'b0}}};

   rd_state_t        state;
   logic [OCC_W-1:0] wr_pix;
   logic [OCC_W-1:0] rd_pix;
   logic [OCC_W-1:0] occ;
   logic             admit_r;
   logic             admit_now;
   logic             line_ok;
   logic             first_pix;
   logic             line_done;
   logic             rd_start;

   // Combinational outputs are gated with rst_n so everything reads zero in reset.
   always_comb begin
      first_pix    = (wr_pix == '0);
      admit_now    = ({1'b0, occ} + LINE_LEN) <= FIFO_SIZE;
      line_ok      = first_pix ? admit_now : admit_r;
      fifo_wr_en   = rst_n && in_valid && line_ok;
      fifo_wr_data = rst_n ? in_data : '0;
      drop_pulse   = rst_n && in_valid && first_pix && !admit_now;
      line_done    = fifo_wr_en && (wr_pix == LAST_PIX);
      rd_start     = (state == IDLE) && out_req && (lines_stored != '0);
      fifo_rd_en   = rst_n && (state == RD_LINE);
      out_busy     = (state != IDLE);
      out_data     = out_valid ? fifo_rd_data : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         wr_pix       <= '0;
         rd_pix       <= '0;
         occ          <= '0;
         admit_r      <= 1'b0;
         lines_stored <= '0;
         drop_cnt     <= '0;
         out_valid    <= 1'b0;
         out_eol      <= 1'b0;
      end else begin
         if (in_valid) begin
            if (first_pix)
               admit_r <= admit_now;
            wr_pix <= (wr_pix == LAST_PIX) ? '0 : wr_pix + 1'b1;
         end

         if (drop_pulse && (drop_cnt != '1))
            drop_cnt <= drop_cnt + 1'b1;

         case ({fifo_wr_en, fifo_rd_en})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase

         // A completing line and a readout start in one cycle cancel out.
         if (line_done && !rd_start && (lines_stored != '1))
            lines_stored <= lines_stored + 1'b1;
         else if (rd_start && !line_done)
            lines_stored <= lines_stored - 1'b1;

         out_valid <= fifo_rd_en;
         out_eol   <= fifo_rd_en && (rd_pix == LAST_PIX);

         unique case (state)
            IDLE: begin
               if (rd_start) begin
                  state  <= RD_LINE;
                  rd_pix <= '0;
               end
            end
            RD_LINE: begin
               rd_pix <= rd_pix + 1'b1;
               if (rd_pix == LAST_PIX)
                  state <= DRAIN;
            end
            DRAIN:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   a_rd_empty: assert property (@(posedge clk) disable iff (!rst_n)
                                !(fifo_rd_en && fifo_rd_empty));
   a_wr_full:  assert property (@(posedge clk) disable iff (!rst_n)
                                !(fifo_wr_en && fifo_wr_full));

endmodule

// File: tb/tb_fifo_line_ctrl.sv
// Directed/random bench for fifo_line_ctrl with a queue-based FIFO and line model.
module tb_fifo_line_ctrl;
   import fifo_line_pkg::*;

   localparam int unsigned DW     = 8;
   localparam int unsigned DEPW   = 12;
   localparam int unsigned H      = 1280;
   localparam int unsigned LCW    = 4;
   localparam int unsigned FDEPTH = 4096;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic [DW-1:0]   in_data = '0;
   logic            out_req = 1'b0;
   logic            out_valid, out_eol, out_busy, drop_pulse;
   logic [DW-1:0]   out_data, fifo_wr_data;
   logic [DW-1:0]   fifo_rd_data = '0;
   logic [LCW-1:0]  lines_stored;
   logic [DROP_CNT_W-1:0] drop_cnt;
   logic            fifo_wr_en, fifo_rd_en, fifo_wr_full, fifo_rd_empty;

   always #5 clk = ~clk;

   fifo_line_ctrl #(
      .DATA_WIDTH (DW),
      .DEPTH_WIDTH(DEPW),
      .H_ACTIVE   (H),
      .LINE_CNT_W (LCW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .out_req      (out_req),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_eol      (out_eol),
      .out_busy     (out_busy),
      .lines_stored (lines_stored),
      .drop_pulse   (drop_pulse),
      .drop_cnt     (drop_cnt),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .fifo_wr_full (fifo_wr_full),
      .fifo_rd_empty(fifo_rd_empty)
   );

   // Behavioural line FIFO with one-cycle read latency, reset together with the controller.
   logic [DW-1:0] fq[$];
   int f_cnt = 0;
   assign fifo_rd_empty = (f_cnt == 0);
   assign fifo_wr_full  = (f_cnt >= FDEPTH);

   always @(posedge clk) begin
      if (!rst_n) begin
         fq.delete();
         f_cnt        <= 0;
         fifo_rd_data <= '0;
      end else begin
         if (fifo_rd_en && (fq.size() != 0))
            fifo_rd_data <= fq.pop_front();
         if (fifo_wr_en)
            fq.push_back(fifo_wr_data);
         f_cnt <= fq.size();
      end
   end

   // Reference model: expected pixel stream and line/drop bookkeeping.
   logic [DW-1:0] exp_q[$];
   int  m_wpix, m_beat, m_drops, m_lines_done, m_started;
   bit  m_admit;
   bit  last_ov, last_eol, last_rd, last_busy;
   int  n_cmp = 0;
   int  n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_wpix = 0; m_beat = 0; m_drops = 0;
      m_lines_done = 0; m_started = 0; m_admit = 0;
   endtask

   task automatic cyc(input bit zchk = 1'b0);
      logic [DW-1:0] e;
      @(negedge clk);
      last_ov = out_valid; last_eol = out_eol; last_rd = fifo_rd_en; last_busy = out_busy;
      if (zchk) begin
         chk("zero_flags", {out_valid, out_eol, out_busy, drop_pulse, fifo_wr_en, fifo_rd_en}, '0);
         chk("zero_counts", {lines_stored, drop_cnt}, '0);
         chk("zero_data", {out_data, fifo_wr_data}, '0);
      end
      if (rst_n) begin
         if (out_valid) begin
            if (exp_q.size() == 0)
               chk("out_extra_beat", out_valid, 1'b0);
            else begin
               e = exp_q.pop_front();
               chk("out_data", out_data, e);
            end
            chk("out_eol", out_eol, (m_beat == H - 1));
            m_beat = (m_beat == H - 1) ? 0 : m_beat + 1;
         end else
            chk("eol_without_valid", out_eol, 1'b0);
         if (fifo_rd_en)
            chk("rd_while_empty", fifo_rd_empty, 1'b0);
         if (in_valid) begin
            if (m_wpix == 0)
               m_admit = (exp_q.size() + H <= FDEPTH);
            chk("wr_en", fifo_wr_en, m_admit);
            chk("drop_pulse", drop_pulse, (m_wpix == 0) && !m_admit);
            if (m_admit) begin
               chk("wr_data", fifo_wr_data, in_data);
               exp_q.push_back(in_data);
            end else if (m_wpix == 0 && m_drops < 65535)
               m_drops++;
            if (m_wpix == H - 1) begin
               m_wpix = 0;
               if (m_admit) m_lines_done++;
            end else
               m_wpix++;
         end else
            chk("wr_idle", {fifo_wr_en, drop_pulse}, '0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0; in_data = '0; out_req = 1'b0;
      model_clear();
      cyc(1'b0);
      cyc(1'b1);
      cyc(1'b1);
      rst_n = 1'b1;
      cyc(1'b1);
   endtask

   // mode 0: descending 0xFF pattern, 1: random contiguous, 2: random at ~50% duty
   task automatic write_line(input int mode, input bit req_last);
      for (int i = 0; i < H; ) begin
         if (mode == 2 && $urandom_range(0, 1) == 0) begin
            in_valid = 1'b0;
            cyc();
            continue;
         end
         in_valid = 1'b1;
         in_data  = (mode == 0) ? DW'(255 - i) : DW'($urandom);
         out_req  = req_last && (i == H - 1);
         cyc();
         i++;
      end
      in_valid = 1'b0; in_data = '0; out_req = 1'b0;
   endtask

   task automatic read_line();
      int beats;
      out_req = 1'b1;
      cyc();
      out_req = 1'b0;
      m_started++;
      chk("ls_after_req", lines_stored, m_lines_done - m_started);
      cyc();
      chk("rd_latency", {last_rd, last_ov, last_busy}, 3'b101);
      cyc();
      chk("out_latency", last_ov, 1'b1);
      beats = 1;
      for (int k = 0; k < H + 8 && !last_eol; k++) begin
         cyc();
         if (last_ov) beats++;
      end
      chk("line_beats", beats, H);
      cyc();
      chk("busy_after_line", last_busy, 1'b0);
   endtask

   initial begin
      int eols, gap, wait_n;
      bit gap_pending;
      model_clear();

      do_reset();

      // single descending line
      write_line(0, 1'b0);
      cyc();
      chk("single_ls", lines_stored, m_lines_done - m_started);
      read_line();
      chk("single_ls_end", lines_stored, m_lines_done - m_started);
      chk("single_drops", drop_cnt, m_drops);

      // overflow: four lines with no reads
      for (int l = 0; l < 4; l++) write_line(1, 1'b0);
      cyc();
      chk("ovf_drop_cnt", drop_cnt, m_drops);
      chk("ovf_drop_one", drop_cnt, 1);
      chk("ovf_ls", lines_stored, m_lines_done - m_started);

      // back-to-back readout with out_req held high
      out_req = 1'b1;
      eols = 0; gap = 0; gap_pending = 0;
      for (int k = 0; k < 3 * (H + 8) && eols < 3; k++) begin
         cyc();
         if (last_ov) begin
            if (gap_pending) chk("b2b_gap", gap, 2);
            gap_pending = 0;
            if (last_eol) begin
               eols++;
               gap_pending = 1;
               gap = 0;
            end
         end else if (gap_pending)
            gap++;
      end
      m_started += 3;
      out_req = 1'b0;
      chk("b2b_lines", eols, 3);
      cyc(); cyc(); cyc();
      chk("b2b_ls_end", lines_stored, m_lines_done - m_started);
      chk("b2b_idle", out_busy, 1'b0);

      // last write of a line coincides with a readout start
      write_line(1, 1'b0);
      write_line(1, 1'b1);
      m_started++;
      chk("simul_ls", lines_stored, m_lines_done - m_started);
      // gapped line written while the readout above runs
      write_line(2, 1'b0);
      wait_n = 0;
      while (out_busy && wait_n < 4 * H) begin
         cyc();
         wait_n++;
      end
      chk("simul_drain_busy", out_busy, 1'b0);
      chk("simul_ls2", lines_stored, m_lines_done - m_started);
      read_line();
      read_line();
      chk("gapped_ls_end", lines_stored, m_lines_done - m_started);

      // reset in the middle of a readout
      write_line(1, 1'b0);
      out_req = 1'b1;
      cyc();
      out_req = 1'b0;
      m_started++;
      wait_n = 0;
      while (m_beat < 640 && wait_n < 2 * H) begin
         cyc();
         wait_n++;
      end
      chk("midrst_reached", m_beat, 640);
      do_reset();
      write_line(1, 1'b0);
      cyc();
      chk("post_rst_ls", lines_stored, m_lines_done - m_started);
      read_line();
      chk("post_rst_ls_end", lines_stored, m_lines_done - m_started);
      chk("post_rst_drops", drop_cnt, m_drops);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
